// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: exception codes, reset vector and fetch FSM encoding.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [4:0]  EXC_ADEL         = 5'h04;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t S_REQ  = 3'd0;
  localparam fetch_state_t S_WAIT = 3'd1;
  localparam fetch_state_t S_HOLD = 3'd2;
  localparam fetch_state_t S_EXC  = 3'd3;
  localparam fetch_state_t S_PARK = 3'd4;
  localparam fetch_state_t S_DROP = 3'd5;

endpackage

// File: rtl/ifetch_pc_gen.sv
// Instruction-fetch PC generator: one-outstanding imem handshake, delay-slot redirects,
// CP0 flush redirects and fetch-address exceptions toward the IF/ID register.
module ifetch_pc_gen
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_target_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        cp0_ex_o,
  output logic [4:0]  cp0_excode_o,
  output logic [31:0] cp0_badvaddr_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_buf_q, inst_buf_d;
  logic         redir_v_q, redir_v_d;
  logic [31:0]  redir_pc_q, redir_pc_d;

  logic        misaligned;
  logic        accepted;
  logic        wait_data;
  logic        advance;
  logic [31:0] pc_adv;

  always_comb begin
    misaligned  = pc_q[1:0] != 2'b00;
    inst_req_o  = (state_q == S_REQ) && !misaligned;
    inst_addr_o = pc_q;
    accepted    = inst_req_o && inst_addr_ok_i;
    wait_data   = (state_q == S_WAIT) && inst_data_ok_i;
    advance     = !flush_i && !stall_i && (wait_data || (state_q == S_HOLD));
    // A pending redirect beats a same-cycle jmp: the delay slot has already gone by.
    pc_adv      = redir_v_q ? redir_pc_q : (jmp_i ? jmp_target_i : pc_q + 32'd4);
  end

  always_comb begin
    pc_o           = '0;
    inst_o         = '0;
    cp0_ex_o       = 1'b0;
    cp0_excode_o   = '0;
    cp0_badvaddr_o = '0;
    if (!flush_i) begin
      case (state_q)
        S_WAIT: begin
          if (inst_data_ok_i) begin
            pc_o   = pc_q;
            inst_o = inst_rdata_i;
          end
        end
        S_HOLD: begin
          pc_o   = pc_q;
          inst_o = inst_buf_q;
        end
        S_EXC: begin
          pc_o           = pc_q;
          cp0_ex_o       = 1'b1;
          cp0_excode_o   = EXC_ADEL;
          cp0_badvaddr_o = pc_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    redir_v_d  = redir_v_q;
    redir_pc_d = redir_pc_q;
    if (flush_i) begin
      pc_d      = flush_pc_i;
      redir_v_d = 1'b0;
      // Any response still owed by memory must be swallowed before refetching.
      if ((state_q == S_WAIT && !inst_data_ok_i) || accepted ||
          (state_q == S_DROP && !inst_data_ok_i)) begin
        state_d = S_DROP;
      end else begin
        state_d = S_REQ;
      end
    end else begin
      if (advance) begin
        pc_d      = pc_adv;
        redir_v_d = 1'b0;
      end else if (!stall_i && jmp_i) begin
        redir_v_d  = 1'b1;
        redir_pc_d = jmp_target_i;
      end
      case (state_q)
        S_REQ: begin
          if (misaligned)          state_d = S_EXC;
          else if (inst_addr_ok_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (inst_data_ok_i) begin
            if (stall_i) begin
              inst_buf_d = inst_rdata_i;
              state_d    = S_HOLD;
            end else begin
              state_d = S_REQ;
            end
          end
        end
        S_HOLD: if (!stall_i) state_d = S_REQ;
        S_EXC:  if (!stall_i) state_d = S_PARK;
        S_PARK: state_d = S_PARK;
        S_DROP: if (inst_data_ok_i) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_buf_q <= '0;
      redir_v_q  <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
      redir_v_q  <= redir_v_d;
      redir_pc_q <= redir_pc_d;
    end
  end

endmodule

// File: tb/tb_ifetch_pc_gen.sv
// Directed bench for ifetch_pc_gen: an abstract fetch model checked every cycle,
// plus hand-computed pinned expectations at key points.
module tb_ifetch_pc_gen;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0, jmp = 1'b0, flush = 1'b0;
  logic [31:0] jmp_target = '0, flush_pc = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic [31:0] pc, inst, cp0_badvaddr;
  logic        cp0_ex;
  logic [4:0]  cp0_excode;

  ifetch_pc_gen dut (
    .clk            (clk),
    .resetn         (resetn),
    .stall_i        (stall),
    .jmp_i          (jmp),
    .jmp_target_i   (jmp_target),
    .flush_i        (flush),
    .flush_pc_i     (flush_pc),
    .inst_req_o     (inst_req),
    .inst_addr_o    (inst_addr),
    .inst_addr_ok_i (inst_addr_ok),
    .inst_data_ok_i (inst_data_ok),
    .inst_rdata_i   (inst_rdata),
    .pc_o           (pc),
    .inst_o         (inst),
    .cp0_ex_o       (cp0_ex),
    .cp0_excode_o   (cp0_excode),
    .cp0_badvaddr_o (cp0_badvaddr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Abstract fetch model: what the fetch unit currently owes or holds.
  logic        m_init = 1'b0;
  logic [31:0] m_pc;
  logic        m_out, m_disc, m_hv, m_exc, m_park;
  logic [31:0] m_buf;
  logic [31:0] m_redir[$];

  // Hand-computed expectations posted by the stimulus for the current cycle.
  logic        pin_v = 1'b0;
  string       pin_nm;
  logic        pin_req, pin_ex;
  logic [31:0] pin_addr, pin_pc, pin_inst, pin_bad;

  logic        e_req, e_ex, e_cons;
  logic [31:0] e_pc, e_inst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic m_idle();
    return !(m_out || m_disc || m_hv || m_exc || m_park);
  endfunction

  task automatic model_out(output logic req, output logic [31:0] opc, output logic [31:0] oinst,
                           output logic ex, output logic cons);
    req = m_idle() && (m_pc[1:0] == 2'b00);
    opc = '0; oinst = '0; ex = 1'b0; cons = 1'b0;
    if (!flush) begin
      if (m_hv) begin
        opc = m_pc; oinst = m_buf; cons = !stall;
      end else if (m_out && inst_data_ok) begin
        opc = m_pc; oinst = inst_rdata; cons = !stall;
      end else if (m_exc) begin
        opc = m_pc; ex = 1'b1;
      end
    end
  endtask

  task automatic model_step();
    logic req, ex, cons, idle;
    logic [31:0] opc, oinst;
    if (!resetn) begin
      m_pc = RST_PC; m_out = 0; m_disc = 0; m_hv = 0; m_exc = 0; m_park = 0; m_buf = '0;
      m_redir.delete();
      m_init = 1'b1;
    end else if (m_init) begin
      model_out(req, opc, oinst, ex, cons);
      idle = m_idle();
      if (flush) begin
        m_disc = (m_out && !inst_data_ok) || (req && inst_addr_ok) || (m_disc && !inst_data_ok);
        m_pc = flush_pc; m_out = 0; m_hv = 0; m_exc = 0; m_park = 0;
        m_redir.delete();
      end else begin
        if (cons) begin
          if (m_redir.size() > 0) m_pc = m_redir.pop_front();
          else if (jmp)           m_pc = jmp_target;
          else                    m_pc = m_pc + 32'd4;
          m_hv = 0; m_out = 0;
        end else begin
          if (!stall && jmp) m_redir = {jmp_target};
          if (m_out && inst_data_ok) begin
            m_hv = 1; m_buf = inst_rdata; m_out = 0;
          end
        end
        if (m_exc && !stall) begin
          m_exc = 0; m_park = 1;
        end
        if (m_disc && inst_data_ok) m_disc = 0;
        if (idle) begin
          if (m_pc[1:0] != 2'b00) m_exc = 1;
          else if (inst_addr_ok)  m_out = 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      model_out(e_req, e_pc, e_inst, e_ex, e_cons);
      chk("inst_req", {31'd0, inst_req}, {31'd0, e_req});
      if (e_req) chk("inst_addr", inst_addr, m_pc);
      chk("pc", pc, e_pc);
      chk("inst", inst, e_inst);
      chk("cp0_ex", {31'd0, cp0_ex}, {31'd0, e_ex});
      chk("cp0_excode", {27'd0, cp0_excode}, e_ex ? 32'd4 : 32'd0);
      chk("cp0_badvaddr", cp0_badvaddr, e_ex ? m_pc : 32'd0);
      if (pin_v) begin
        chk({pin_nm, ".req"}, {31'd0, inst_req}, {31'd0, pin_req});
        if (pin_req) chk({pin_nm, ".addr"}, inst_addr, pin_addr);
        chk({pin_nm, ".pc"}, pc, pin_pc);
        chk({pin_nm, ".inst"}, inst, pin_inst);
        chk({pin_nm, ".ex"}, {31'd0, cp0_ex}, {31'd0, pin_ex});
        chk({pin_nm, ".bad"}, cp0_badvaddr, pin_bad);
      end
    end
    model_step();
  end

  task automatic pin(input string nm, input logic req, input logic [31:0] addr,
                     input logic [31:0] p, input logic [31:0] i, input logic ex,
                     input logic [31:0] bad);
    pin_nm = nm; pin_req = req; pin_addr = addr; pin_pc = p; pin_inst = i;
    pin_ex = ex; pin_bad = bad; pin_v = 1'b1;
  endtask

  task automatic cyc(input logic st, input logic aok, input logic dok, input logic [31:0] rd,
                     input logic j, input logic [31:0] jt, input logic fl,
                     input logic [31:0] fp);
    stall = st; inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
    jmp = j; jmp_target = jt; flush = fl; flush_pc = fp;
    @(posedge clk);
    #1;
    pin_v = 1'b0;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    // Sequential fetch, best-case timing
    pin("rst", 1, RST_PC, 0, 0, 0, 0);                       cyc(0, 1, 0, 0, 0, 0, 0, 0);
    pin("first", 0, 0, RST_PC, 32'h2408_0001, 0, 0);         cyc(0, 0, 1, 32'h2408_0001, 0, 0, 0, 0);
    pin("next", 1, 32'hBFC0_0004, 0, 0, 0, 0);               cyc(0, 1, 0, 0, 0, 0, 0, 0);
    // Stall spanning data_ok; a stalled jmp must be ignored
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    pin("hold0", 0, 0, 32'hBFC0_0004, 32'h11, 0, 0);         cyc(1, 0, 1, 32'h11, 0, 0, 0, 0);
    pin("hold1", 0, 0, 32'hBFC0_0004, 32'h11, 0, 0);         cyc(1, 0, 0, 0, 1, 32'hDEAD_0000, 0, 0);
    pin("hold2", 0, 0, 32'hBFC0_0004, 32'h11, 0, 0);         cyc(0, 0, 0, 0, 0, 0, 0, 0);
    pin("seq", 1, 32'hBFC0_0008, 0, 0, 0, 0);                cyc(0, 1, 0, 0, 0, 0, 0, 0);
    // Branch during S_WAIT: delay slot delivered, then target
    cyc(0, 0, 0, 0, 1, 32'hBFC0_0100, 0, 0);
    pin("dslot", 0, 0, 32'hBFC0_0008, 32'h22, 0, 0);         cyc(0, 0, 1, 32'h22, 0, 0, 0, 0);
    pin("tgt", 1, 32'hBFC0_0100, 0, 0, 0, 0);                cyc(0, 1, 0, 0, 0, 0, 0, 0);
    // Flush in S_WAIT; stale response discarded
    pin("flsh", 0, 0, 0, 0, 0, 0);                           cyc(0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0380);
    pin("drop", 0, 0, 0, 0, 0, 0);                           cyc(0, 0, 0, 0, 0, 0, 0, 0);
    pin("drop_d", 0, 0, 0, 0, 0, 0);                         cyc(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    pin("vec", 1, 32'hBFC0_0380, 0, 0, 0, 0);                cyc(0, 1, 0, 0, 0, 0, 0, 0);
    pin("vec_d", 0, 0, 32'hBFC0_0380, 32'h33, 0, 0);         cyc(0, 0, 1, 32'h33, 1, 32'hBFC0_0102, 0, 0);
    // Misaligned target: AdEL, then park until flush
    pin("mis", 0, 0, 0, 0, 0, 0);                            cyc(0, 0, 0, 0, 0, 0, 0, 0);
    pin("adel0", 0, 0, 32'hBFC0_0102, 0, 1, 32'hBFC0_0102); cyc(1, 0, 0, 0, 0, 0, 0, 0);
    pin("adel1", 0, 0, 32'hBFC0_0102, 0, 1, 32'hBFC0_0102); cyc(0, 0, 0, 0, 0, 0, 0, 0);
    pin("park0", 0, 0, 0, 0, 0, 0);                          cyc(0, 1, 0, 0, 0, 0, 0, 0);
    pin("park1", 0, 0, 0, 0, 0, 0);                          cyc(0, 1, 1, 32'h55, 0, 0, 0, 0);
    pin("pk_fl", 0, 0, 0, 0, 0, 0);                          cyc(0, 0, 0, 0, 0, 0, 1, RST_PC);
    pin("resume", 1, RST_PC, 0, 0, 0, 0);                    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    // Flush with data_ok in S_WAIT goes straight to S_REQ
    pin("fl_dok", 0, 0, 0, 0, 0, 0);                         cyc(0, 0, 1, 32'h66, 0, 0, 1, 32'hBFC0_0200);
    // Flush while the request is being accepted: response must be dropped
    pin("fl_acc", 1, 32'hBFC0_0200, 0, 0, 0, 0);             cyc(0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    pin("drop2", 0, 0, 0, 0, 0, 0);                          cyc(0, 0, 1, 32'h77, 0, 0, 0, 0);
    // PC wraps past the top of the address space
    pin("wrap0", 1, 32'hFFFF_FFFC, 0, 0, 0, 0);              cyc(0, 1, 0, 0, 0, 0, 0, 0);
    pin("wrap_d", 0, 0, 32'hFFFF_FFFC, 32'h88, 0, 0);        cyc(0, 0, 1, 32'h88, 0, 0, 0, 0);
    pin("wrap", 1, 32'h0, 0, 0, 0, 0);                       cyc(0, 1, 0, 0, 0, 0, 0, 0);
    // Reset in the middle of S_HOLD
    pin("hold_r", 0, 0, 0, 32'h99, 0, 0);                    cyc(1, 0, 1, 32'h99, 0, 0, 0, 0);
    resetn = 1'b0;
    pin("hold_r2", 0, 0, 0, 32'h99, 0, 0);                   cyc(1, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    pin("post_rst", 1, RST_PC, 0, 0, 0, 0);                  cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
